conv_window_gen: RTL and testbench

Streaming window generator that sits directly upstream of the `convolution` stage and feeds its `conv2d` layer. It accepts one raster-order pixel per beat, with all input channels packed. It produces one zero-padded 3x3 window per output position for a 3x3, PADDING=1 convolution at STRIDE 1 or 2. Two line buffers hold the previous rows, and a 3-column shift register forms the window.

---
 rtl/conv_window_gen.sv | 155 +++++++++++++++
 tb/tb_conv_window_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to zero-padded 3x3 windows, stride 1/2.
// Optional macro CONV_WINDOW_GEN_COORD_EN adds o_win_row/o_win_col outputs.
module conv_window_gen #(
    parameter int IN_WIDTH   = 64,
    parameter int IN_HEIGHT  = 64,
    parameter int IN_CHANNEL = 3,
    parameter int DATA_WIDTH = 8,
    parameter int STRIDE     = 2
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic                               i_pix_valid,
    output logic                               o_pix_ready,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0]   i_pix_data,
    output logic                               o_win_valid,
    input  logic                               i_win_ready,
    output logic [9*IN_CHANNEL*DATA_WIDTH-1:0] o_win_data,
    output logic                               o_win_last
`ifdef CONV_WINDOW_GEN_COORD_EN
    ,
    output logic [$clog2(IN_HEIGHT)-1:0]       o_win_row,
    output logic [$clog2(IN_WIDTH)-1:0]        o_win_col
`endif
);

    localparam int PW = IN_CHANNEL * DATA_WIDTH;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int RW = $clog2(IN_HEIGHT + 1);
    localparam int AW = $clog2(IN_WIDTH);
    localparam int OH = (IN_HEIGHT - 1) / STRIDE + 1;
    localparam int OW = (IN_WIDTH - 1) / STRIDE + 1;
    localparam logic [CW-1:0] C_END  = CW'(IN_WIDTH);
    localparam logic [RW-1:0] R_END  = RW'(IN_HEIGHT);
    localparam logic [CW-1:0] C_LAST = CW'((OW - 1) * STRIDE + 1);
    localparam logic [RW-1:0] R_LAST = RW'((OH - 1) * STRIDE + 1);
`ifdef CONV_WINDOW_GEN_COORD_EN
    localparam int ROW_W = $clog2(IN_HEIGHT);
    localparam int COL_W = $clog2(IN_WIDTH);
`endif

    typedef enum logic {ACCEPT, PAD} state_t;

    // column of three pixels, index 0 is the top row
    typedef logic [2:0][PW-1:0] col_t;

    state_t            state;
    logic [RW-1:0]     row, row_n;
    logic [CW-1:0]     col, col_n;
    logic              sel;
    logic [PW-1:0]     lb0 [IN_WIDTH];
    logic [PW-1:0]     lb1 [IN_WIDTH];
    logic [AW-1:0]     lb_idx;
    logic [PW-1:0]     pix, old_px, new_px;
    col_t              new_col, win_c1_q, win_c2_q;
    logic [2:0][2:0][PW-1:0] win_cols;
    logic [9*PW-1:0]   win_d;
    logic              at_pad_col, at_pad_row;
    logic              emit, is_last, out_free, proc;

    // Window assembly, emission decision and handshake qualification
    always_comb begin
        at_pad_col = (col == C_END);
        at_pad_row = (row == R_END);
        lb_idx     = col[AW-1:0];
        new_px     = sel ? lb1[lb_idx] : lb0[lb_idx];
        old_px     = sel ? lb0[lb_idx] : lb1[lb_idx];
        pix        = at_pad_row ? '0 : i_pix_data;

        new_col[0] = (row > RW'(1)) ? old_px : '0;
        new_col[1] = (row != '0) ? new_px : '0;
        new_col[2] = pix;
        if (at_pad_col)
            new_col = '0;

        win_cols[0] = (col == '0) ? '0 : win_c1_q;
        win_cols[1] = (col == '0) ? '0 : win_c2_q;
        win_cols[2] = new_col;

        win_d = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                win_d[(ky*3+kx)*PW +: PW] = win_cols[kx][ky];

        // (r-1) and (c-1) even is the same as r and c odd
        emit = (row != '0) && (col != '0) &&
               (STRIDE == 1 || (row[0] && col[0]));
        is_last  = (row == R_LAST) && (col == C_LAST);
        out_free = !o_win_valid || i_win_ready;

        o_pix_ready = (state == ACCEPT) && (!emit || out_free);
        proc = (state == ACCEPT) ? (i_pix_valid && o_pix_ready)
                                 : (!emit || out_free);

        row_n = row;
        col_n = col + CW'(1);
        if (at_pad_col) begin
            col_n = '0;
            row_n = at_pad_row ? '0 : row + RW'(1);
        end
    end

    // Position scan FSM, line-buffer rotation and window column shift
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= ACCEPT;
            row      <= '0;
            col      <= '0;
            sel      <= 1'b0;
            win_c1_q <= '0;
            win_c2_q <= '0;
        end else if (proc) begin
            row      <= row_n;
            col      <= col_n;
            state    <= (row_n == R_END || col_n == C_END) ? PAD : ACCEPT;
            win_c1_q <= win_cols[1];
            win_c2_q <= win_cols[2];
            if (at_pad_col)
                sel <= ~sel;
        end
    end

    // Line buffer RAM: overwrite the older row after it has been read
    always_ff @(posedge i_Clk) begin
        if (proc && !at_pad_col) begin
            if (sel)
                lb0[lb_idx] <= pix;
            else
                lb1[lb_idx] <= pix;
        end
    end

    // Output register: load on emit, hold under backpressure
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_win_valid <= 1'b0;
            o_win_data  <= '0;
            o_win_last  <= 1'b0;
`ifdef CONV_WINDOW_GEN_COORD_EN
            o_win_row   <= '0;
            o_win_col   <= '0;
`endif
        end else if (proc && emit) begin
            o_win_valid <= 1'b1;
            o_win_data  <= win_d;
            o_win_last  <= is_last;
`ifdef CONV_WINDOW_GEN_COORD_EN
            o_win_row   <= ROW_W'((row - RW'(1)) >> (STRIDE - 1));
            o_win_col   <= COL_W'((col - CW'(1)) >> (STRIDE - 1));
`endif
        end else if (i_win_ready) begin
            o_win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed table checks of conv_window_gen on a 4x4 image.
// Covers content, stride 1, backpressure, back-to-back frames, mid-frame reset.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        win_ready = 1'b1;
    logic        pix_ready, win_valid, win_last;
    logic [71:0] win_data;

    logic        s1_en = 1'b0;
    logic        v1;
    logic        pix_ready1, win_valid1, win_last1;
    logic [71:0] win_data1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;

    logic [71:0] wq[$];
    logic        lq[$];
    logic [71:0] w1q[$];
    logic        l1q[$];

`ifdef CONV_WINDOW_GEN_COORD_EN
    logic [1:0] win_row, win_col, win_row1, win_col1;
    logic [3:0] cq[$];
`endif

    typedef struct {
        int          oy;
        int          ox;
        logic [71:0] win;
        logic        last;
    } vec_t;

    vec_t tbl[4];

    assign v1 = pix_valid & s1_en;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv_window_gen #(
        .IN_WIDTH(4), .IN_HEIGHT(4), .IN_CHANNEL(1),
        .DATA_WIDTH(8), .STRIDE(2)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_pix_valid(pix_valid),
        .o_pix_ready(pix_ready),
        .i_pix_data(pix_data),
        .o_win_valid(win_valid),
        .i_win_ready(win_ready),
        .o_win_data(win_data),
        .o_win_last(win_last)
`ifdef CONV_WINDOW_GEN_COORD_EN
        ,
        .o_win_row(win_row),
        .o_win_col(win_col)
`endif
    );

    conv_window_gen #(
        .IN_WIDTH(4), .IN_HEIGHT(4), .IN_CHANNEL(1),
        .DATA_WIDTH(8), .STRIDE(1)
    ) dut1 (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_pix_valid(v1),
        .o_pix_ready(pix_ready1),
        .i_pix_data(pix_data),
        .o_win_valid(win_valid1),
        .i_win_ready(1'b1),
        .o_win_data(win_data1),
        .o_win_last(win_last1)
`ifdef CONV_WINDOW_GEN_COORD_EN
        ,
        .o_win_row(win_row1),
        .o_win_col(win_col1)
`endif
    );

    // Collect consumed windows and accepted pixels between clock edges
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && win_ready) begin
                wq.push_back(win_data);
                lq.push_back(win_last);
`ifdef CONV_WINDOW_GEN_COORD_EN
                cq.push_back({win_row, win_col});
`endif
            end
            if (win_valid1) begin
                w1q.push_back(win_data1);
                l1q.push_back(win_last1);
            end
            if (pix_valid && pix_ready)
                acc_cnt++;
        end
    end

    function automatic logic [71:0] mkw(input int a0, input int a1,
                                        input int a2, input int a3,
                                        input int a4, input int a5,
                                        input int a6, input int a7,
                                        input int a8);
        logic [71:0] w;
        w = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4),
             8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input int first, input int n, output int t0);
        logic ok;
        t0 = -1;
        for (int i = 0; i < n; i++) begin
            int g;
            g = 0;
            pix_valid = 1'b1;
            pix_data  = 8'(first + i);
            do begin
                @(negedge clk);
                ok = pix_ready;
                g++;
            end while (!ok && g < 300);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: pixel %0d not accepted", first + i);
                pix_valid = 1'b0;
                return;
            end
            if (i == 0)
                t0 = cyc;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic clear_q();
        wq.delete();
        lq.delete();
        w1q.delete();
        l1q.delete();
`ifdef CONV_WINDOW_GEN_COORD_EN
        cq.delete();
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
    endtask

    task automatic check_tbl(input string nm);
        chk({nm, "_count"}, 72'(wq.size()), 72'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_win%0d", nm, i), wq[i], tbl[i].win);
                chk($sformatf("%s_last%0d", nm, i),
                    72'(lq[i]), 72'(tbl[i].last));
`ifdef CONV_WINDOW_GEN_COORD_EN
                chk($sformatf("%s_coord%0d", nm, i), 72'(cq[i]),
                    72'({2'(tbl[i].oy), 2'(tbl[i].ox)}));
`endif
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb2, tc;
        logic [71:0] held;
        logic stable;

        tbl[0] = '{0, 0, mkw(0, 0, 0, 0, 1, 2, 0, 5, 6), 1'b0};
        tbl[1] = '{0, 1, mkw(0, 0, 0, 2, 3, 4, 6, 7, 8), 1'b0};
        tbl[2] = '{1, 0, mkw(0, 5, 6, 0, 9, 10, 0, 13, 14), 1'b0};
        tbl[3] = '{1, 1, mkw(6, 7, 8, 10, 11, 12, 14, 15, 16), 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pix_ready", 72'(pix_ready), 72'(1));
        chk("rst_win_valid", 72'(win_valid), 72'(0));
        chk("rst_win_data", win_data, 72'(0));
        chk("rst_win_last", 72'(win_last), 72'(0));

        // basic content, stride 2 and stride 1 side by side
        @(posedge clk);
        #1;
        clear_q();
        s1_en = 1'b1;
        send(1, 16, ta);
        repeat (12) @(posedge clk);
        #1;
        s1_en = 1'b0;
        check_tbl("s2");
        chk("s1_count", 72'(w1q.size()), 72'(16));
        if (w1q.size() == 16) begin
            chk("s1_win0", w1q[0], mkw(0, 0, 0, 0, 1, 2, 0, 5, 6));
            chk("s1_win5", w1q[5], mkw(1, 2, 3, 5, 6, 7, 9, 10, 11));
            chk("s1_win15", w1q[15], mkw(11, 12, 0, 15, 16, 0, 0, 0, 0));
            chk("s1_last14", 72'(l1q[14]), 72'(0));
            chk("s1_last15", 72'(l1q[15]), 72'(1));
        end

        // backpressure on the first window
        pulse_reset();
        acc_cnt = 0;
        fork
            send(1, 16, tb2);
            begin
                int g;
                g = 0;
                stable = 1'b1;
                do begin
                    @(posedge clk);
                    #1;
                    g++;
                end while (!win_valid && g < 100);
                chk("bp_valid_seen", 72'(win_valid), 72'(1));
                win_ready = 1'b0;
                held = win_data;
                repeat (10) begin
                    @(negedge clk);
                    if (win_data !== held)
                        stable = 1'b0;
                end
                chk("bp_stable", 72'(stable), 72'(1));
                chk("bp_held_data", held, tbl[0].win);
                chk("bp_accepted", 72'(acc_cnt), 72'(7));
                chk("bp_still_valid", 72'(win_valid), 72'(1));
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check_tbl("bp");

        // back-to-back frames
        pulse_reset();
        send(1, 16, ta);
        send(101, 16, tc);
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_frame_cycles", 72'(tc - ta), 72'(25));
        chk("b2b_count", 72'(wq.size()), 72'(8));
        if (wq.size() == 8) begin
            chk("b2b_f1_win0", wq[0], tbl[0].win);
            chk("b2b_f1_last", 72'(lq[3]), 72'(1));
            chk("b2b_f2_win0", wq[4],
                mkw(0, 0, 0, 0, 101, 102, 0, 105, 106));
            chk("b2b_f2_last0", 72'(lq[4]), 72'(0));
            chk("b2b_f2_win3", wq[7],
                mkw(106, 107, 108, 110, 111, 112, 114, 115, 116));
            chk("b2b_f2_last3", 72'(lq[7]), 72'(1));
        end

        // reset mid-frame with a window pending
        pulse_reset();
        win_ready = 1'b0;
        send(1, 7, ta);
        chk("mid_pending", 72'(win_valid), 72'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 72'(win_valid), 72'(0));
        chk("mid_rst_ready", 72'(pix_ready), 72'(1));
        @(posedge clk);
        #1;
        clear_q();
        send(1, 16, ta);
        repeat (12) @(posedge clk);
        #1;
        check_tbl("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
